// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned DIGITS = 2
);

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit double-dabble correction: add 3 to a digit that is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adj_c
);

    // 4-bit add, no carry out of the digit
    assign adj_c = (digit >= BCD_ADJ_THRESH) ? bcd_digit_t'(digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned DIGITS = 2
) (
    input logic            Clock,
    input logic            Resetn,
    bin_to_bcd_seq_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SCR_W = 4 * DIGITS;

    conv_state_t          state;
    logic [WIDTH-1:0]     shreg;
    logic [SCR_W-1:0]     scratch;
    logic [SCR_W-1:0]     adj_c;
    logic [CNT_W-1:0]     cnt;
    logic                 sticky;
    logic                 busy_q;
    logic                 done_q;
    logic [SCR_W-1:0]     bcd_q;
    logic                 overflow_q;

    // Conditional +3 on every scratch digit ahead of the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch[4*g +: 4]),
            .adj_c (adj_c[4*g +: 4])
        );
    end

    // Control FSM, shift datapath and registered result outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            shreg      <= '0;
            scratch    <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjusted digits and operand shift left as one register;
                    // whatever leaves the top digit marks the value as too large.
                    scratch <= {adj_c[SCR_W-2:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    sticky  <= sticky | adj_c[SCR_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    bcd_q      <= scratch;
                    overflow_q <= sticky;
                    done_q     <= 1'b1;
                    if (bus.start) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 5-bit and an 8-bit instance, both two digits.
module tb_bin_to_bcd_seq;

    logic Clock  = 1'b0;
    logic Resetn = 1'b1;

    bin_to_bcd_seq_if #(.WIDTH(5), .DIGITS(2)) b5 ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) b8 ();

    bin_to_bcd_seq #(.WIDTH(5), .DIGITS(2)) u5 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (b5)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u8 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (b8)
    );

    always #5 Clock = ~Clock;

    int n_pass  = 0;
    int n_total = 0;

    // Unified views of both instances
    logic       st   [2];
    int         bn   [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic [7:0] d_bcd  [2];
    logic       d_ovf  [2];
    int         wdt  [2] = '{5, 8};

    assign st[0]     = b5.start;
    assign st[1]     = b8.start;
    assign bn[0]     = int'(b5.bin);
    assign bn[1]     = int'(b8.bin);
    assign d_busy[0] = b5.busy;
    assign d_busy[1] = b8.busy;
    assign d_done[0] = b5.done;
    assign d_done[1] = b8.done;
    assign d_bcd[0]  = b5.bcd;
    assign d_bcd[1]  = b8.bcd;
    assign d_ovf[0]  = b5.overflow;
    assign d_ovf[1]  = b8.overflow;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Decimal digits of v mod 100, packed two digits per byte
    function automatic logic [7:0] to_bcd(input int v);
        int x;
        logic [7:0] r;
        x = v % 100;
        r[3:0] = 4'(x % 10);
        r[7:4] = 4'(x / 10);
        return r;
    endfunction

    // Transaction model: each accepted request completes WIDTH+1 edges later
    int         age   [2] = '{-1, -1};
    int         val   [2] = '{0, 0};
    logic [7:0] m_bcd [2] = '{8'h00, 8'h00};
    logic       m_ovf [2] = '{1'b0, 1'b0};
    logic       m_done[2] = '{1'b0, 1'b0};
    logic       m_busy[2] = '{1'b0, 1'b0};

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            age[i] = -1; m_bcd[i] = 8'h00; m_ovf[i] = 1'b0;
            m_done[i] = 1'b0; m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (age[i] >= 0) age[i]++;
            if (age[i] == wdt[i] + 1) begin
                m_bcd[i]  = to_bcd(val[i]);
                m_ovf[i]  = (val[i] >= 100);
                m_done[i] = 1'b1;
                age[i]    = -1;
            end
            if (age[i] < 0 && st[i]) begin
                age[i] = 0;
                val[i] = bn[i];
            end
            m_busy[i] = (age[i] >= 0) && (age[i] < wdt[i]);
        end
    endtask

    initial begin
        forever begin
            @(negedge Resetn);
            model_clear();
        end
    end

    // Model update on every edge, DUT comparison just after it
    initial begin
        forever begin
            @(posedge Clock);
            if (!Resetn) model_clear();
            else         model_step();
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.busy", i), 32'(d_busy[i]), 32'(m_busy[i]));
                check($sformatf("u%0d.done", i), 32'(d_done[i]), 32'(m_done[i]));
                check($sformatf("u%0d.bcd", i),  32'(d_bcd[i]),  32'(m_bcd[i]));
                check($sformatf("u%0d.ovf", i),  32'(d_ovf[i]),  32'(m_ovf[i]));
            end
        end
    end

    task automatic drive(input int i, input logic s, input int unsigned v);
        if (i == 0) begin b5.start = s; b5.bin = 5'(v); end
        else        begin b8.start = s; b8.bin = 8'(v); end
    endtask

    // One request; lat = edges from the accepting edge to the done cycle
    task automatic convert(input int i, input int unsigned v, output int lat);
        logic got;
        @(negedge Clock);
        drive(i, 1'b1, v);
        @(posedge Clock);
        #1;
        drive(i, 1'b0, $urandom);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(posedge Clock);
            #1;
            if (d_done[i]) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    int lat;
    int cnt;
    int t1, t2;
    logic [7:0] b1, b2;

    initial begin
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        #1 Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", 32'(b5.busy), 0);
        check("rst_done", 32'(b5.done), 0);
        check("rst_bcd", 32'(b5.bcd), 0);
        check("rst_ovf", 32'(b5.overflow), 0);
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock);
        #1;
        check("post_rst_bcd", 32'(b5.bcd), 0);

        // First conversion
        convert(0, 31, lat);
        check("lat31", 32'(lat), 6);
        check("bcd31", 32'(d_bcd[0]), 32'h31);
        check("ovf31", 32'(d_ovf[0]), 0);
        check("model31", 32'(m_bcd[0]), 32'h31);

        // Full 5-bit sweep
        for (int v = 0; v < 32; v++) begin
            convert(0, v, lat);
            check($sformatf("sweep_lat_%0d", v), 32'(lat), 6);
            check($sformatf("sweep_bcd_%0d", v), 32'(d_bcd[0]), 32'((v / 10) * 16 + (v % 10)));
        end

        // Overflow on the 8-bit instance
        convert(1, 255, lat);
        check("lat255", 32'(lat), 9);
        check("bcd255", 32'(d_bcd[1]), 32'h55);
        check("ovf255", 32'(d_ovf[1]), 1);
        check("model255", 32'(m_ovf[1]), 1);
        convert(1, 99, lat);
        check("bcd99", 32'(d_bcd[1]), 32'h99);
        check("ovf99", 32'(d_ovf[1]), 0);

        // Start during SHIFT is ignored
        @(negedge Clock) drive(0, 1'b1, 17);
        @(posedge Clock);
        #1 drive(0, 1'b0, 0);
        repeat (2) @(posedge Clock);
        @(negedge Clock) drive(0, 1'b1, 3);
        @(negedge Clock) drive(0, 1'b0, 3);
        cnt = 0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (d_done[0]) cnt++;
        end
        check("ign_done_cnt", 32'(cnt), 1);
        check("ign_bcd", 32'(d_bcd[0]), 32'h17);

        // Back-to-back with start held high
        @(negedge Clock) drive(0, 1'b1, 17);
        @(posedge Clock);
        #1 drive(0, 1'b1, 20);
        t1 = 0; t2 = 0; b1 = '0; b2 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clock);
            #1;
            if (d_done[0]) begin
                if (t1 == 0) begin t1 = k; b1 = d_bcd[0]; end
                else if (t2 == 0) begin t2 = k; b2 = d_bcd[0]; end
            end
            if (k == 7) drive(0, 1'b0, 0);
        end
        check("b2b_t1", 32'(t1), 6);
        check("b2b_gap", 32'(t2 - t1), 6);
        check("b2b_bcd1", 32'(b1), 32'h17);
        check("b2b_bcd2", 32'(b2), 32'h20);

        // Reset three cycles into a conversion
        @(negedge Clock) drive(0, 1'b1, 31);
        @(posedge Clock);
        #1 drive(0, 1'b0, 0);
        repeat (3) @(posedge Clock);
        #3 Resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(b5.busy), 0);
        check("mid_rst_done", 32'(b5.done), 0);
        check("mid_rst_bcd", 32'(b5.bcd), 0);
        check("mid_rst_ovf", 32'(b5.overflow), 0);
        check("mid_rst_bcd8", 32'(b8.bcd), 0);
        @(negedge Clock) Resetn = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge Clock);
            #1;
            if (d_done[0]) cnt++;
        end
        check("mid_rst_no_done", 32'(cnt), 0);
        convert(0, 9, lat);
        check("lat9", 32'(lat), 6);
        check("bcd9", 32'(d_bcd[0]), 32'h09);

        // Result holds while idle
        cnt = 0;
        repeat (20) begin
            @(posedge Clock);
            #1;
            if (d_done[0]) cnt++;
        end
        check("hold_done", 32'(cnt), 0);
        check("hold_bcd", 32'(d_bcd[0]), 32'h09);
        check("hold_ovf", 32'(d_ovf[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
